// File: rtl/sal_bank_timing_checker.sv
// Per-bank timing checker: tracks the last granted command to one DRAM bank and
// reports which bank-level timing constraints are currently satisfied.
module sal_bank_timing_checker #(
    parameter int TW         = 5,
    parameter int RFCW       = 8,
    parameter int ROW_OPEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TW-1:0]         t_rcd_m1,
    input  logic [TW-1:0]         t_rp_m1,
    input  logic [TW-1:0]         t_ras_m1,
    input  logic [TW-1:0]         t_rtp_m1,
    input  logic [TW-1:0]         t_wtp_m1,
    input  logic [RFCW-1:0]       t_rfc_m1,
    input  logic [ROW_OPEN_W-1:0] row_open_cnt,
    input  logic                  act_gnt,
    input  logic                  rd_gnt,
    input  logic                  wr_gnt,
    input  logic                  pre_gnt,
    input  logic                  ref_gnt,
    output logic                  is_t_rcd_met,
    output logic                  is_t_rp_met,
    output logic                  is_t_ras_met,
    output logic                  is_t_rtp_met,
    output logic                  is_t_wtp_met,
    output logic                  is_t_rfc_met,
    output logic                  is_pre_ready,
    output logic                  row_open_timeout,
    output logic [1:0]            bank_state,
    output logic                  cmd_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        REFRESH = 2'd2
    } state_e;

    state_e                state, next_state;
    logic [TW-1:0]         rcd_cnt, rp_cnt, ras_cnt, rtp_cnt, wtp_cnt;
    logic [RFCW-1:0]       rfc_cnt;
    logic [ROW_OPEN_W-1:0] idle_cnt, idle_cnt_next;
    logic [2:0]            gnt_count;
    logic                  multi_gnt, illegal;
    logic                  load_act, load_rd, load_wr, load_pre, load_ref;

    function automatic logic [TW-1:0] step(input logic load, input logic [TW-1:0] value,
                                           input logic [TW-1:0] cnt);
        if (load)
            return value;
        else if (cnt != '0)
            return cnt - TW'(1);
        else
            return cnt;
    endfunction

    // Every output is decoded from registers, so no grant reaches an output combinationally.
    assign is_t_rcd_met     = (rcd_cnt == '0);
    assign is_t_rp_met      = (rp_cnt == '0);
    assign is_t_ras_met     = (ras_cnt == '0);
    assign is_t_rtp_met     = (rtp_cnt == '0);
    assign is_t_wtp_met     = (wtp_cnt == '0);
    assign is_t_rfc_met     = (rfc_cnt == '0);
    assign is_pre_ready     = is_t_ras_met & is_t_rtp_met & is_t_wtp_met;
    assign bank_state       = state;
    assign row_open_timeout = (state == ACTIVE) && (idle_cnt == row_open_cnt) && (row_open_cnt != '0);

    assign gnt_count = {2'b0, act_gnt} + {2'b0, rd_gnt} + {2'b0, wr_gnt}
                     + {2'b0, pre_gnt} + {2'b0, ref_gnt};
    assign multi_gnt = (gnt_count > 3'd1);
    assign load_act  = act_gnt & ~multi_gnt;
    assign load_rd   = rd_gnt  & ~multi_gnt;
    assign load_wr   = wr_gnt  & ~multi_gnt;
    assign load_pre  = pre_gnt & ~multi_gnt;
    assign load_ref  = ref_gnt & ~multi_gnt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        next_state    = state;
        illegal       = multi_gnt;
        idle_cnt_next = '0;

        if (act_gnt && !((state == IDLE) && is_t_rp_met && is_t_rfc_met))
            illegal = 1'b1;
        if ((rd_gnt || wr_gnt) && !((state == ACTIVE) && is_t_rcd_met))
            illegal = 1'b1;
        if (pre_gnt && !((state == ACTIVE) && is_pre_ready))
            illegal = 1'b1;
        if (ref_gnt && !((state == IDLE) && is_t_rp_met))
            illegal = 1'b1;

        if (!multi_gnt) begin
            unique case (state)
                IDLE: begin
                    if (act_gnt)
                        next_state = ACTIVE;
                    else if (ref_gnt)
                        next_state = REFRESH;
                end
                ACTIVE: begin
                    if (pre_gnt)
                        next_state = IDLE;
                end
                REFRESH: begin
                    if (is_t_rfc_met)
                        next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end

        // Idle counter only runs while the row stays open and nothing touches it.
        if ((state == ACTIVE) && (next_state == ACTIVE) && !(load_act || load_rd || load_wr)) begin
            if (idle_cnt < row_open_cnt)
                idle_cnt_next = idle_cnt + ROW_OPEN_W'(1);
            else
                idle_cnt_next = idle_cnt;
        end
    end

    // NOTE: synchronous reset is sampled only at the clock edge, so it overrides any grant there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rcd_cnt  <= '0;
            rp_cnt   <= '0;
            ras_cnt  <= '0;
            rtp_cnt  <= '0;
            wtp_cnt  <= '0;
            rfc_cnt  <= '0;
            idle_cnt <= '0;
            cmd_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            state    <= next_state;
            rcd_cnt  <= step(load_act, t_rcd_m1, rcd_cnt);
            ras_cnt  <= step(load_act, t_ras_m1, ras_cnt);
            rtp_cnt  <= step(load_rd,  t_rtp_m1, rtp_cnt);
            wtp_cnt  <= step(load_wr,  t_wtp_m1, wtp_cnt);
            rp_cnt   <= step(load_pre, t_rp_m1,  rp_cnt);
            if (load_ref)
                rfc_cnt <= t_rfc_m1;
            else if (rfc_cnt != '0)
                rfc_cnt <= rfc_cnt - RFCW'(1);
            idle_cnt <= idle_cnt_next;
            cmd_err  <= illegal;
        end
    end

endmodule

// File: tb/tb_sal_bank_timing_checker.sv
// Scoreboard bench: stimulus queues expected values tagged with a cycle number,
// a negedge monitor compares and retires them as each cycle arrives.
module tb_sal_bank_timing_checker;

    localparam int TW         = 5;
    localparam int RFCW       = 8;
    localparam int ROW_OPEN_W = 8;

    localparam logic [4:0] G_ACT = 5'b10000;
    localparam logic [4:0] G_RD  = 5'b01000;
    localparam logic [4:0] G_WR  = 5'b00100;
    localparam logic [4:0] G_PRE = 5'b00010;
    localparam logic [4:0] G_REF = 5'b00001;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [TW-1:0]         t_rcd_m1, t_rp_m1, t_ras_m1, t_rtp_m1, t_wtp_m1;
    logic [RFCW-1:0]       t_rfc_m1;
    logic [ROW_OPEN_W-1:0] row_open_cnt;
    logic                  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic                  is_t_rcd_met, is_t_rp_met, is_t_ras_met, is_t_rtp_met;
    logic                  is_t_wtp_met, is_t_rfc_met, is_pre_ready, row_open_timeout;
    logic [1:0]            bank_state;
    logic                  cmd_err;

    sal_bank_timing_checker #(.TW(TW), .RFCW(RFCW), .ROW_OPEN_W(ROW_OPEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1),
        .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1), .t_rfc_m1(t_rfc_m1),
        .row_open_cnt(row_open_cnt),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .is_t_rcd_met(is_t_rcd_met), .is_t_rp_met(is_t_rp_met), .is_t_ras_met(is_t_ras_met),
        .is_t_rtp_met(is_t_rtp_met), .is_t_wtp_met(is_t_wtp_met), .is_t_rfc_met(is_t_rfc_met),
        .is_pre_ready(is_pre_ready), .row_open_timeout(row_open_timeout),
        .bank_state(bank_state), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef enum int {S_RCD, S_RP, S_RAS, S_RTP, S_WTP, S_RFC, S_PRE, S_TMO, S_STATE, S_ERR} sig_e;
    typedef struct {
        int    at;
        sig_e  sig;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input sig_e s);
        case (s)
            S_RCD:   return int'(is_t_rcd_met);
            S_RP:    return int'(is_t_rp_met);
            S_RAS:   return int'(is_t_ras_met);
            S_RTP:   return int'(is_t_rtp_met);
            S_WTP:   return int'(is_t_wtp_met);
            S_RFC:   return int'(is_t_rfc_met);
            S_PRE:   return int'(is_pre_ready);
            S_TMO:   return int'(row_open_timeout);
            S_STATE: return int'(bank_state);
            S_ERR:   return int'(cmd_err);
            default: return -1;
        endcase
    endfunction

    task automatic check(input string nm, input int got, input int want_v);
        checks++;
        if (got !== want_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want_v);
        end
    endtask

    task automatic want(input int at, input sig_e s, input int v, input string nm);
        q.push_back('{at, s, v, nm});
    endtask

    // Monitor: retire every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at == cyc) begin
                check($sformatf("%s@%0d", q[i].name, q[i].at), actual(q[i].sig), q[i].val);
                q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] g);
        {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} = g;
        tick();
        {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} = '0;
    endtask

    initial begin
        int t;
        rst_n        = 1'b0;
        {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} = G_ACT;
        t_rcd_m1     = 5'd3;
        t_rp_m1      = 5'd2;
        t_ras_m1     = 5'd9;
        t_rtp_m1     = 5'd1;
        t_wtp_m1     = 5'd6;
        t_rfc_m1     = 8'd20;
        row_open_cnt = 8'd0;

        // Reset held with act_gnt high
        repeat (3) tick();
        t = cyc;
        want(t, S_RCD, 1, "rst_rcd");
        want(t, S_RP, 1, "rst_rp");
        want(t, S_RAS, 1, "rst_ras");
        want(t, S_RTP, 1, "rst_rtp");
        want(t, S_WTP, 1, "rst_wtp");
        want(t, S_RFC, 1, "rst_rfc");
        want(t, S_PRE, 1, "rst_pre_ready");
        want(t, S_STATE, 0, "rst_state");
        want(t, S_ERR, 0, "rst_err");
        want(t, S_TMO, 0, "rst_tmo");
        rst_n = 1'b1;
        {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} = '0;
        tick();

        // tRCD / tRAS after a legal ACT, then a legal PRE
        t = cyc;
        want(t + 1, S_STATE, 1, "act_state");
        want(t + 1, S_ERR, 0, "act_err");
        want(t + 1, S_RCD, 0, "rcd_low_first");
        want(t + 3, S_RCD, 0, "rcd_low_last");
        want(t + 4, S_RCD, 1, "rcd_met");
        want(t + 1, S_RAS, 0, "ras_low_first");
        want(t + 9, S_RAS, 0, "ras_low_last");
        want(t + 10, S_RAS, 1, "ras_met");
        want(t + 9, S_PRE, 0, "pre_ready_low");
        want(t + 10, S_PRE, 1, "pre_ready_high");
        issue(G_ACT);
        repeat (10) tick();
        t = cyc;
        want(t + 1, S_STATE, 0, "pre_state");
        want(t + 1, S_ERR, 0, "pre_err");
        want(t + 2, S_RP, 0, "rp_low_last");
        want(t + 3, S_RP, 1, "rp_met");
        issue(G_PRE);
        repeat (3) tick();

        // Early precharge: illegal but still closes the row and loads tRP
        t = cyc;
        issue(G_ACT);
        repeat (4) tick();
        want(t + 6, S_ERR, 1, "early_pre_err");
        want(t + 7, S_ERR, 0, "early_pre_err_clear");
        want(t + 6, S_STATE, 0, "early_pre_state");
        want(t + 6, S_RP, 0, "early_pre_rp");
        issue(G_PRE);
        repeat (5) tick();

        // Refresh, with an illegal ACT in the middle
        t = cyc;
        want(t + 1, S_STATE, 2, "ref_state_first");
        want(t + 1, S_ERR, 0, "ref_err");
        want(t + 20, S_RFC, 0, "rfc_low_last");
        want(t + 21, S_RFC, 1, "rfc_met");
        want(t + 21, S_STATE, 2, "ref_state_last");
        want(t + 22, S_STATE, 0, "ref_exit");
        issue(G_REF);
        repeat (9) tick();
        want(t + 11, S_ERR, 1, "act_in_ref_err");
        want(t + 12, S_ERR, 0, "act_in_ref_err_clear");
        want(t + 11, S_STATE, 2, "act_in_ref_state");
        want(t + 11, S_RCD, 0, "act_in_ref_rcd_loaded");
        issue(G_ACT);
        repeat (11) tick();

        // Row-open timeout and its clear on RD
        row_open_cnt = 8'd4;
        t = cyc;
        want(t + 4, S_TMO, 0, "tmo_not_yet");
        want(t + 5, S_TMO, 1, "tmo_set");
        want(t + 8, S_TMO, 1, "tmo_held");
        want(t + 9, S_TMO, 0, "tmo_clr_by_rd");
        want(t + 10, S_TMO, 0, "tmo_restart");
        want(t + 9, S_ERR, 0, "rd_err");
        want(t + 9, S_RTP, 0, "rtp_low");
        want(t + 10, S_RTP, 1, "rtp_met");
        issue(G_ACT);
        repeat (7) tick();
        issue(G_RD);
        tick();
        row_open_cnt = 8'd0;
        want(t + 16, S_TMO, 0, "tmo_disabled_a");
        want(t + 20, S_TMO, 0, "tmo_disabled_b");
        repeat (10) tick();

        // Back-to-back WR, then a RD+WR multi-grant that must not reload anything
        t = cyc;
        want(t + 1, S_WTP, 0, "wtp_low_first");
        want(t + 4, S_ERR, 0, "wr2_err");
        want(t + 9, S_WTP, 0, "wtp_low_last");
        want(t + 10, S_WTP, 1, "wtp_met");
        want(t + 9, S_PRE, 0, "wtp_pre_low");
        want(t + 10, S_PRE, 1, "wtp_pre_high");
        want(t + 5, S_ERR, 1, "multi_err");
        want(t + 6, S_ERR, 0, "multi_err_clear");
        want(t + 5, S_RTP, 1, "multi_no_rtp_load");
        want(t + 5, S_STATE, 1, "multi_state");
        want(t + 11, S_STATE, 0, "wtp_pre_state");
        want(t + 11, S_ERR, 0, "wtp_pre_err");
        issue(G_WR);
        repeat (2) tick();
        issue(G_WR);
        issue(G_RD | G_WR);
        repeat (5) tick();
        issue(G_PRE);
        repeat (2) tick();

        // Reset asserted mid-count overrides an illegal PRE
        t = cyc;
        issue(G_ACT);
        rst_n   = 1'b0;
        pre_gnt = 1'b1;
        want(t + 2, S_RCD, 1, "midrst_rcd");
        want(t + 2, S_RAS, 1, "midrst_ras");
        want(t + 2, S_STATE, 0, "midrst_state");
        want(t + 2, S_ERR, 0, "midrst_err");
        tick();
        rst_n   = 1'b1;
        pre_gnt = 1'b0;
        tick();

        for (int k = 0; k < 200 && q.size() > 0; k++)
            tick();
        foreach (q[i]) begin
            checks++;
            failures++;
            $display("FAIL %s@%0d: never compared, expected %0d", q[i].name, q[i].at, q[i].val);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
